ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 5, meaning RAM address width (32 words).
REQ-002 The block SHALL have parameter DW, default 4, meaning RAM data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each: access request, held until granted.
REQ-006 The block SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read; valid while reqN=1.
REQ-007 The block SHALL have ports addr0/addr1, input, AW bits each: access address.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DW bits each: write data.
REQ-009 The block SHALL have ports gnt0/gnt1, output, 1 bit each: access performed at the rising edge ending this cycle.
REQ-010 The block SHALL have ports rdata0/rdata1, output, DW bits each: registered read data.
REQ-011 The block SHALL have ports rvalid0/rvalid1, output, 1 bit each: one-cycle pulse, rdataN valid.
REQ-012 The block SHALL have ports ram_we (1 bit), ram_a (AW bits) and ram_di (DW bits), outputs driving the single-port RAM.
REQ-013 The block SHALL have port ram_do, input, DW bits: asynchronous RAM read data.

Function
REQ-014 The block SHALL grant at most one requester per cycle; gnt0 and gnt1 SHALL never both be 1.
REQ-015 gntN SHALL be combinational from req0, req1 and the registered priority bit prio; it SHALL NOT depend on we, addr or wdata.
REQ-016 Arbitration: a single requester SHALL win; with both requesting, port prio SHALL win.
REQ-017 At each edge with a grant, prio SHALL become the non-granted port; with no grant, prio SHALL hold.
REQ-018 With port N granted, ram_we=weN, ram_a=addrN and ram_di=wdataN SHALL be driven combinationally in the same cycle.
REQ-019 With no grant, ram_we=0, ram_a=0 and ram_di=0 SHALL be driven.
REQ-020 A granted write SHALL commit in the RAM at the edge ending the grant cycle; rvalidN SHALL stay 0.
REQ-021 A granted read SHALL capture ram_do into rdataN at the edge ending the grant cycle, and rvalidN SHALL be 1 for exactly the following cycle. Read latency SHALL be 1 cycle from the grant edge.
REQ-022 rdataN SHALL hold its last captured value until the next read by port N.
REQ-023 With both ports requesting continuously, grants SHALL alternate every cycle; neither port SHALL wait more than 1 cycle.
REQ-024 Back-to-back reads by one port SHALL produce rvalidN on consecutive cycles, each with the data of its own access.
REQ-025 A requester that drops reqN before its grant SHALL have no access performed; no state besides prio is affected.
REQ-026 Same-address write by one port then read by the other on the next cycle SHALL return the new data.

Reset
REQ-027 On rst_n=0, independent of clk, the block SHALL immediately set prio=0, rvalid0=rvalid1=0 and rdata0=rdata1=0.
REQ-028 During reset, gnt0=gnt1=0 and ram_we=0 SHALL be forced regardless of requests; RAM contents are not cleared.
REQ-029 A request pending when reset asserts SHALL be dropped; the requester SHALL re-present it after reset.
REQ-030 After rst_n deasserts, the first edge with a request SHALL arbitrate normally with prio=0.

Structure
REQ-031 AW/DW defaults and the port-index encoding (PORT0=0, PORT1=1) SHALL live in a shared package ram_pkg.
REQ-032 Priority selection and the prio register SHALL be one sub-module, rr_arb2 (req[1:0] -> gnt[1:0]).
REQ-033 The RAM SHALL stay external; the bench SHALL connect the existing 32x4 single-port async-read RAM.

Verification
REQ-034 Port 0 writes addr 4 = 1010, then port 0 reads addr 4 -> gnt0 each cycle; rvalid0 pulses and rdata0=1010.
REQ-035 Both ports read continuously (addr 8 = 1100, addr 15 = 0011 preloaded), starting at prio=0 -> grants go 0,1,0,1; rdata0=1100, rdata1=0011.
REQ-036 Port 1 writes addr 8 = 0110 and port 0 reads addr 8 in the next cycle -> rdata0=0110.
REQ-037 req0 raised then dropped while port 1 holds the grant -> no gnt0; RAM addr contents unchanged; prio unaffected by port 0.
REQ-038 rst_n pulled low mid-read between clock edges -> rvalid, rdata and gnt go to 0 at once; after release, with both ports requesting, port 0 is granted first.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared sizing defaults and port-index encoding for the
// two-port RAM arbiter and its priority sub-block.
package ram_pkg;

    localparam int unsigned AW_DEFAULT = 5;
    localparam int unsigned DW_DEFAULT = 4;
    localparam int unsigned NUM_PORTS  = 2;

    // Requester index; also the encoding of the round-robin priority bit.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // The port that is not p.
    function automatic port_e other_port(input port_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per port
//   gnt[1:0]   : combinational one-hot (or zero) grant
// The grant depends only on req and the registered priority bit, and is
// forced to zero while reset is asserted.
module rr_arb2
    import ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);

    port_e                prio_q;
    port_e                prio_d;
    logic [NUM_PORTS-1:0] gnt_c;
    port_e                winner_c;

    // Grant selection and next priority
    always_comb begin
        gnt_c    = '0;
        winner_c = PORT0;
        prio_d   = prio_q;
        if (rst_n) begin
            if (req[PORT0] && req[PORT1]) begin
                gnt_c[prio_q] = 1'b1;
            end else begin
                gnt_c = req;
            end
        end
        // After any grant the other port becomes favoured; idle cycles hold.
        if (gnt_c != '0) begin
            winner_c = gnt_c[PORT1] ? PORT1 : PORT0;
            prio_d   = other_port(winner_c);
        end
    end

    assign gnt = gnt_c;

    // Priority register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PORT0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one external single-port, async-read RAM between two
// requesters.
//   clk, rst_n             : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN  : port N access request (held until granted)
//   gntN                   : combinational grant; access happens at the
//                            rising edge ending this cycle
//   rdataN/rvalidN         : registered read data and its one-cycle valid
//   ram_we/ram_a/ram_di    : combinational RAM controls (zero when idle)
//   ram_do                 : asynchronous RAM read data
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    logic [NUM_PORTS-1:0] req_c;
    logic [NUM_PORTS-1:0] gnt_c;

    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    assign req_c[PORT0] = req0;
    assign req_c[PORT1] = req1;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_c),
        .gnt   (gnt_c)
    );

    assign gnt0 = gnt_c[PORT0];
    assign gnt1 = gnt_c[PORT1];

    // RAM port mux from the granted requester
    always_comb begin
        ram_we = 1'b0;
        ram_a  = '0;
        ram_di = '0;
        if (gnt_c[PORT0]) begin
            ram_we = we0;
            ram_a  = addr0;
            ram_di = wdata0;
        end else if (gnt_c[PORT1]) begin
            ram_we = we1;
            ram_a  = addr1;
            ram_di = wdata1;
        end
    end

    // Read-return capture: a granted read latches ram_do; data holds otherwise
    always_comb begin
        rvalid0_d = gnt_c[PORT0] && !we0;
        rvalid1_d = gnt_c[PORT1] && !we1;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (rvalid0_d) begin
            rdata0_d = ram_do;
        end
        if (rvalid1_d) begin
            rdata1_d = ram_do;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// 32x4 single-port async-read RAM model attached.
module tb_ram_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 4;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic [DW-1:0] rdata0, rdata1;
    logic          rvalid0, rvalid1;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    // Bench-side preload port into the RAM model
    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [DW-1:0] pre_d;

    int n_checks;
    int n_fail;

    logic [DW-1:0] mem [0:31];

    assign ram_do = mem[ram_a];

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (ram_we) mem[ram_a] <= ram_di;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd4, 4'hF, 1'b1, 1'b1, 5'd8, 4'hF);
        @(posedge clk);
        #1;
        n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0 got %b exp 0", gnt0); end
        n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1 got %b exp 0", gnt1); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL rst_rvalid got %b%b exp 00", rvalid0, rvalid1); end
        n_checks++; if (rdata0 !== 4'h0 || rdata1 !== 4'h0) begin
            n_fail++; $display("FAIL rst_rdata got %h/%h exp 0/0", rdata0, rdata1); end
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
    endtask

    // Port 0 writes addr 4 = 1010 then reads it back
    task automatic test_write_read;
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd4, 4'b1010, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL wr_gnt got %b%b exp 10", gnt0, gnt1); end
        n_checks++; if (ram_we !== 1'b1 || ram_a !== 5'd4 || ram_di !== 4'b1010) begin
            n_fail++; $display("FAIL wr_ram got we=%b a=%0d di=%b exp we=1 a=4 di=1010", ram_we, ram_a, ram_di); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid0 got %b exp 0", rvalid0); end
        n_checks++; if (mem[4] !== 4'b1010) begin n_fail++; $display("FAIL wr_mem4 got %b exp 1010", mem[4]); end
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd4, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        n_checks++; if (gnt0 !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL rd_gnt got gnt0=%b we=%b exp 1/0", gnt0, ram_we); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'b1010) begin
            n_fail++; $display("FAIL rd_data got v=%b d=%b exp 1/1010", rvalid0, rdata0); end
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        @(posedge clk);
        #1;
        n_checks++; if (rvalid0 !== 1'b0 || rdata0 !== 4'b1010) begin
            n_fail++; $display("FAIL rd_pulse got v=%b d=%b exp 0/1010", rvalid0, rdata0); end
    endtask

    // Both ports read continuously from prio=0: grants 0,1,0,1
    task automatic test_round_robin;
        logic eg0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(1'b1, 1'b0, 5'd8, 4'h0, 1'b1, 1'b0, 5'd15, 4'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            eg0 = ((i % 2) == 0);
            #1;
            n_checks++; if (gnt0 !== eg0 || gnt1 !== !eg0) begin
                n_fail++; $display("FAIL rr_gnt[%0d] got %b%b exp %b%b", i, gnt0, gnt1, eg0, !eg0); end
            n_checks++; if (ram_a !== (eg0 ? 5'd8 : 5'd15)) begin
                n_fail++; $display("FAIL rr_addr[%0d] got %0d exp %0d", i, ram_a, eg0 ? 8 : 15); end
            @(posedge clk);
            #1;
            n_checks++; if (rvalid0 !== eg0 || rvalid1 !== !eg0) begin
                n_fail++; $display("FAIL rr_rvalid[%0d] got %b%b exp %b%b", i, rvalid0, rvalid1, eg0, !eg0); end
            n_checks++; if (rdata0 !== 4'b1100 || rdata1 !== ((i >= 1) ? 4'b0011 : 4'b0000)) begin
                n_fail++; $display("FAIL rr_rdata[%0d] got %b/%b", i, rdata0, rdata1); end
        end
    endtask

    // Port 1 writes addr 8 = 0110, port 0 reads it on the next cycle
    task automatic test_write_then_read;
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1, 1'b1, 5'd8, 4'b0110);
        #1;
        n_checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_we !== 1'b1 || ram_a !== 5'd8 || ram_di !== 4'b0110) begin
            n_fail++; $display("FAIL wtr_wr got g=%b%b we=%b a=%0d di=%b", gnt0, gnt1, ram_we, ram_a, ram_di); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL wtr_rvalid1 got %b exp 0", rvalid1); end
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd8, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL wtr_gnt0 got %b exp 1", gnt0); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'b0110) begin
            n_fail++; $display("FAIL wtr_rdata0 got v=%b d=%b exp 1/0110", rvalid0, rdata0); end
    endtask

    // req0 raised while port 1 wins, then dropped: no port-0 access
    task automatic test_drop;
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd3, 4'b1111, 1'b1, 1'b0, 5'd15, 4'h0);
        #1;
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || ram_a !== 5'd15 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL drop_gnt got g=%b%b a=%0d we=%b exp g=01 a=15 we=0", gnt0, gnt1, ram_a, ram_we); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid1 !== 1'b1 || rdata1 !== 4'b0011 || rvalid0 !== 1'b0) begin
            n_fail++; $display("FAIL drop_rd1 got v1=%b d1=%b v0=%b", rvalid1, rdata1, rvalid0); end
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd3, 4'b1111, 1'b0, 1'b0, 5'd0, 4'h0);
        #1;
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0 || ram_a !== 5'd0 || ram_di !== 4'h0) begin
            n_fail++; $display("FAIL idle_bus got g=%b%b we=%b a=%0d di=%b exp all 0", gnt0, gnt1, ram_we, ram_a, ram_di); end
        @(posedge clk);
        #1;
        n_checks++; if (mem[3] !== 4'b0101 || rvalid0 !== 1'b0) begin
            n_fail++; $display("FAIL drop_mem3 got %b v0=%b exp 0101/0", mem[3], rvalid0); end
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd3, 4'h0, 1'b1, 1'b0, 5'd15, 4'h0);
        #1;
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL drop_prio got %b%b exp 10", gnt0, gnt1); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'b0101) begin
            n_fail++; $display("FAIL drop_rd0 got v=%b d=%b exp 1/0101", rvalid0, rdata0); end
    endtask

    // Port 0 reads three addresses on consecutive cycles
    task automatic test_back_to_back;
        logic [AW-1:0] a [3];
        logic [DW-1:0] e [3];
        a[0] = 5'd8;  e[0] = 4'b0110;
        a[1] = 5'd15; e[1] = 4'b0011;
        a[2] = 5'd4;  e[2] = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, a[i], 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
            @(posedge clk);
            #1;
            n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== e[i]) begin
                n_fail++; $display("FAIL b2b[%0d] got v=%b d=%b exp 1/%b", i, rvalid0, rdata0, e[i]); end
        end
    endtask

    // Reset asserted between edges while a read result is showing
    task automatic test_reset_mid;
        #2;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 5'd15, 4'h0, 1'b1, 1'b0, 5'd8, 4'h0);
        #1;
        n_checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_rvalid got %b%b exp 00", rvalid0, rvalid1); end
        n_checks++; if (rdata0 !== 4'h0 || rdata1 !== 4'h0) begin
            n_fail++; $display("FAIL mid_rst_rdata got %h/%h exp 0/0", rdata0, rdata1); end
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_gnt got g=%b%b we=%b exp 000", gnt0, gnt1, ram_we); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_a !== 5'd15) begin
            n_fail++; $display("FAIL post_rst_gnt got g=%b%b a=%0d exp 10 a=15", gnt0, gnt1, ram_a); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'b0011 || rvalid1 !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_rd got v0=%b d0=%b v1=%b", rvalid0, rdata0, rvalid1); end
        @(negedge clk);
        #1;
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_alt got %b%b exp 01", gnt0, gnt1); end
        n_checks++; if (mem[4] !== 4'b1010) begin
            n_fail++; $display("FAIL rst_keeps_mem got %b exp 1010", mem[4]); end
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        @(posedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pre_we   = 1'b0;
        pre_a    = '0;
        pre_d    = '0;
        drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 5'd0, 4'h0);
        test_reset;
        preload(5'd3,  4'b0101);
        preload(5'd4,  4'b0000);
        preload(5'd8,  4'b1100);
        preload(5'd15, 4'b0011);
        @(negedge clk);
        rst_n = 1'b1;
        test_write_read;
        test_round_robin;
        test_write_then_read;
        test_drop;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
